four_bit_full_adder: RTL and testbench



---
 rtl/full_adder_1bit.sv | 21 ++
 rtl/four_bit_full_adder.sv | 58 +++++
 tb/tb_four_bit_full_adder.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/full_adder_1bit.sv
// One-bit full adder built from gate primitives; the leaf cell of the ripple chain.
module full_adder_1bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic co
);

   logic abXor;
   logic abAnd;
   logic propAnd;

   // The propagate term a^b feeds both the sum and the carry path.
   xor gXorAb   (abXor, a, b);
   xor gXorSum  (s, abXor, cin);
   and gAndGen  (abAnd, a, b);
   and gAndProp (propAnd, cin, abXor);
   or  gOrCarry (co, abAnd, propAnd);

endmodule

// File: rtl/four_bit_full_adder.sv
// 4-bit ripple-carry adder with a live combinational result and a registered copy
// (sum, carry, signed overflow, valid) for pipelined consumers.
module four_bit_full_adder (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   input  logic       in_valid,
   output logic [3:0] sum,
   output logic       cout,
   output logic [3:0] sum_q,
   output logic       cout_q,
   output logic       ovf_q,
   output logic       valid_q
);

   logic [4:0] carry;
   logic [3:0] sum_d;
   logic       cout_d;
   logic       ovf_d;

   assign carry[0] = cin;

   // carry[i] is the carry into bit i; carry[4] leaves the MSB.
   for (genvar i = 0; i < 4; i++) begin : gRipple
      full_adder_1bit uFa (
         .a   (a[i]),
         .b   (b[i]),
         .cin (carry[i]),
         .s   (sum[i]),
         .co  (carry[i+1])
      );
   end

   assign cout   = carry[4];
   assign sum_d  = sum;
   assign cout_d = carry[4];
   assign ovf_d  = carry[3] ^ carry[4];

   // Result registers only load on qualified inputs; valid tracks every cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q   <= 4'd0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= in_valid;
         if (in_valid) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
         end
      end
   end

endmodule

// File: tb/tb_four_bit_full_adder.sv
// Directed self-checking bench for four_bit_full_adder: exhaustive combinational sweep,
// corner sums, register capture/hold, overflow and asynchronous reset.
module tb_four_bit_full_adder;

   logic       clk;
   logic       rst_n;
   logic [3:0] a;
   logic [3:0] b;
   logic       cin;
   logic       in_valid;
   logic [3:0] sum;
   logic       cout;
   logic [3:0] sum_q;
   logic       cout_q;
   logic       ovf_q;
   logic       valid_q;

   int testsRun  = 0;
   int testsFail = 0;

   four_bit_full_adder dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .in_valid (in_valid),
      .sum      (sum),
      .cout     (cout),
      .sum_q    (sum_q),
      .cout_q   (cout_q),
      .ovf_q    (ovf_q),
      .valid_q  (valid_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case anything stalls the directed sequence.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input logic [3:0] aIn, input logic [3:0] bIn,
                                input logic cinIn, input logic validIn);
      a        = aIn;
      b        = bIn;
      cin      = cinIn;
      in_valid = validIn;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         testsFail++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Packs the registered outputs as {valid, ovf, cout, sum}.
   function automatic logic [7:0] regView();
      return {1'b0, valid_q, ovf_q, cout_q, sum_q};
   endfunction

   function automatic logic [7:0] regExp(input logic v, input logic o, input logic c,
                                         input logic [3:0] s);
      return {1'b0, v, o, c, s};
   endfunction

   initial begin
      logic [4:0] expSum;

      rst_n = 1'b0;
      applyStimulus(4'd3, 4'd4, 1'b0, 1'b1);
      #2;
      checkOutput("resetRegs", regView(), regExp(1'b0, 1'b0, 1'b0, 4'd0));
      checkOutput("combInReset", {3'b0, cout, sum}, 8'h07);

      @(negedge clk);
      applyStimulus(4'd0, 4'd0, 1'b0, 1'b0);
      rst_n = 1'b1;

      for (int ai = 0; ai < 16; ai++) begin
         for (int bi = 0; bi < 16; bi++) begin
            for (int ci = 0; ci < 2; ci++) begin
               applyStimulus(4'(ai), 4'(bi), 1'(ci), 1'b0);
               #1;
               expSum = 5'(ai + bi + ci);
               testsRun++;
               assert ({cout, sum} === expSum)
               else begin
                  testsFail++;
                  $error("[TB] FAIL exhaustive a=%0d b=%0d cin=%0d: observed=%0d expected=%0d",
                         ai, bi, ci, {cout, sum}, expSum);
               end
            end
         end
      end

      @(negedge clk);
      checkOutput("holdAfterSweep", regView(), regExp(1'b0, 1'b0, 1'b0, 4'd0));

      applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b0);
      #1 checkOutput("cornerMax", {3'b0, cout, sum}, 8'h1F);
      applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0);
      #1 checkOutput("cornerWrap", {3'b0, cout, sum}, 8'h10);
      applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
      #1 checkOutput("cornerZero", {3'b0, cout, sum}, 8'h00);

      @(negedge clk);
      applyStimulus(4'b0101, 4'b0011, 1'b0, 1'b1);
      @(posedge clk);
      @(negedge clk);
      checkOutput("capture5p3", regView(), regExp(1'b1, 1'b1, 1'b0, 4'b1000));
      applyStimulus(4'b1001, 4'b0110, 1'b1, 1'b0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("holdNoValid", regView(), regExp(1'b0, 1'b1, 1'b0, 4'b1000));

      applyStimulus(4'b1000, 4'b1000, 1'b0, 1'b1);
      @(posedge clk);
      @(negedge clk);
      checkOutput("ovfNegNeg", regView(), regExp(1'b1, 1'b1, 1'b1, 4'b0000));

      applyStimulus(4'b1111, 4'b0001, 1'b0, 1'b1);
      @(posedge clk);
      @(negedge clk);
      checkOutput("carryNoOvf", regView(), regExp(1'b1, 1'b0, 1'b1, 4'b0000));

      applyStimulus(4'b0101, 4'b0011, 1'b0, 1'b1);
      @(posedge clk);
      @(negedge clk);
      checkOutput("reload", regView(), regExp(1'b1, 1'b1, 1'b0, 4'b1000));

      #2;
      rst_n = 1'b0;
      applyStimulus(4'd6, 4'd7, 1'b1, 1'b1);
      #1;
      checkOutput("asyncResetRegs", regView(), regExp(1'b0, 1'b0, 1'b0, 4'd0));
      checkOutput("asyncResetComb", {3'b0, cout, sum}, 8'h0E);
      @(posedge clk);
      #1;
      checkOutput("resetHeldOverEdge", regView(), regExp(1'b0, 1'b0, 1'b0, 4'd0));

      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("captureAfterReset", regView(), regExp(1'b1, 1'b1, 1'b0, 4'b1110));

      applyStimulus(4'd0, 4'd0, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("holdAfterReset", regView(), regExp(1'b0, 1'b1, 1'b0, 4'b1110));

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
      $finish;
   end

endmodule
